// File: rtl/lin_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lin_sched_pkg : shared types and constants for the LIN scheduler     |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package lin_sched_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ISSUE       = 3'd1,
        WAIT_FRAME  = 3'd2,
        SLOT_WAIT   = 3'd3,
        SLEEP_ISSUE = 3'd4,
        SLEEP       = 3'd5
    } state_e;

    localparam logic [5:0] SLEEP_ID = 6'h3C;
    localparam logic [7:0] ERR_MAX  = 8'd255;

endpackage
`default_nettype wire

// File: rtl/lin_schedule_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lin_schedule_ctrl_if : header request / frame status handshake       |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
interface lin_schedule_ctrl_if;
    logic       hdr_req;
    logic [5:0] hdr_id;
    logic       hdr_ack;
    logic       frame_done;
    logic       frame_err;

    modport master (output hdr_req, hdr_id, input hdr_ack, frame_done, frame_err);
    modport slave  (input hdr_req, hdr_id, output hdr_ack, frame_done, frame_err);
endinterface
`default_nettype wire

// File: rtl/lin_sched_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lin_sched_table : schedule entries, sync write / combinational read  |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module lin_sched_table #(
    parameter  int N_SLOTS = 8,
    parameter  int LEN_W   = 16,
    localparam int IDX_W   = $clog2(N_SLOTS)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             we_i,
    input  wire logic [IDX_W-1:0] waddr_i,
    input  wire logic [5:0]       wid_i,
    input  wire logic [LEN_W-1:0] wlen_i,
    input  wire logic [IDX_W-1:0] raddr_i,
    output logic      [5:0]       rid_o,
    output logic      [LEN_W-1:0] rlen_o
);
    logic [5:0]       id_q  [N_SLOTS];
    logic [LEN_W-1:0] len_q [N_SLOTS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                id_q[i]  <= '0;
                len_q[i] <= '0;
            end
        end else if (we_i) begin
            id_q[waddr_i]  <= wid_i;
            len_q[waddr_i] <= wlen_i;
        end
    end

    assign rid_o  = id_q[raddr_i];
    assign rlen_o = len_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/lin_schedule_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lin_schedule_ctrl : LIN master schedule-table sequencer with sleep    |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module lin_schedule_ctrl
    import lin_sched_pkg::*;
#(
    parameter  int N_SLOTS = 8,
    parameter  int LEN_W   = 16,
    localparam int IDX_W   = $clog2(N_SLOTS)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             en_i,
    input  wire logic             tick_i,
    input  wire logic             cfg_we_i,
    input  wire logic [IDX_W-1:0] cfg_addr_i,
    input  wire logic [5:0]       cfg_id_i,
    input  wire logic [LEN_W-1:0] cfg_len_i,
    input  wire logic [IDX_W:0]   cfg_num_i,
    input  wire logic             sleep_req_i,
    input  wire logic             wake_req_i,
    lin_schedule_ctrl_if.master   hdr_if,
    output logic      [IDX_W-1:0] slot_idx_o,
    output logic      [7:0]       err_cnt_o,
    output logic                  busy_o,
    output logic                  asleep_o
);
    localparam logic [LEN_W-1:0] LEN_ONE = 1;
    localparam logic [IDX_W:0]   IDX_ONE = 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] slot_idx_q, slot_idx_d;
    logic [LEN_W-1:0] timer_q, timer_d;
    logic [LEN_W-1:0] snap_len_q;
    logic [5:0]       snap_id_q;
    logic [7:0]       err_cnt_q;
    logic             sleep_q, sleep_d;
    logic             sleep_frame_q, sleep_frame_d;

    logic [5:0]       tbl_id;
    logic [LEN_W-1:0] tbl_len;
    logic [IDX_W:0]   idx_inc;
    logic [IDX_W-1:0] next_idx;
    logic             reached, slot_end, err_inc, load_snap;

    // Table is addressed by the next index so the snapshot lands with the state change.
    lin_sched_table #(.N_SLOTS(N_SLOTS), .LEN_W(LEN_W)) u_table (
        .clk     (clk),
        .reset   (reset),
        .we_i    (cfg_we_i),
        .waddr_i (cfg_addr_i),
        .wid_i   (cfg_id_i),
        .wlen_i  (cfg_len_i),
        .raddr_i (slot_idx_d),
        .rid_o   (tbl_id),
        .rlen_o  (tbl_len)
    );

    assign idx_inc  = {1'b0, slot_idx_q} + IDX_ONE;
    assign next_idx = (idx_inc >= cfg_num_i) ? '0 : idx_inc[IDX_W-1:0];
    assign reached  = (timer_q >= snap_len_q);

    always_comb begin
        state_d       = state_q;
        slot_idx_d    = slot_idx_q;
        timer_d       = timer_q;
        sleep_frame_d = sleep_frame_q;
        sleep_d       = sleep_q | (sleep_req_i & busy_o);
        err_inc       = 1'b0;
        slot_end      = 1'b0;

        if ((state_q == WAIT_FRAME || state_q == SLOT_WAIT) && tick_i && !reached)
            timer_d = timer_q + LEN_ONE;

        case (state_q)
            IDLE: begin
                if (sleep_req_i) begin
                    state_d = SLEEP_ISSUE;
                end else if (en_i && cfg_num_i != '0) begin
                    state_d    = ISSUE;
                    slot_idx_d = '0;
                end
            end
            ISSUE, SLEEP_ISSUE: begin
                if (hdr_if.hdr_ack) begin
                    state_d       = WAIT_FRAME;
                    timer_d       = '0;
                    sleep_frame_d = (state_q == SLEEP_ISSUE);
                end
            end
            WAIT_FRAME: begin
                // A response completing on the timeout cycle is a success, not a timeout.
                if (hdr_if.frame_done || hdr_if.frame_err) begin
                    err_inc = hdr_if.frame_err;
                    if (sleep_frame_q)  state_d  = SLEEP;
                    else if (reached)   slot_end = 1'b1;
                    else                state_d  = SLOT_WAIT;
                end else if (reached) begin
                    err_inc = 1'b1;
                    if (sleep_frame_q)  state_d  = SLEEP;
                    else                slot_end = 1'b1;
                end
            end
            SLOT_WAIT: begin
                if (reached) slot_end = 1'b1;
            end
            SLEEP: begin
                if (wake_req_i) begin
                    state_d = IDLE;
                    sleep_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (slot_end) begin
            slot_idx_d = next_idx;
            if (sleep_q || sleep_req_i) state_d = SLEEP_ISSUE;
            else if (!en_i)             state_d = IDLE;
            else                        state_d = ISSUE;
        end
    end

    assign load_snap = (state_d == ISSUE || state_d == SLEEP_ISSUE) && (state_d != state_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            slot_idx_q    <= '0;
            timer_q       <= '0;
            snap_len_q    <= '0;
            snap_id_q     <= '0;
            err_cnt_q     <= '0;
            sleep_q       <= 1'b0;
            sleep_frame_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_idx_q    <= slot_idx_d;
            timer_q       <= timer_d;
            sleep_q       <= sleep_d;
            sleep_frame_q <= sleep_frame_d;
            if (err_inc && err_cnt_q != ERR_MAX)
                err_cnt_q <= err_cnt_q + 8'd1;
            if (load_snap) begin
                snap_id_q  <= tbl_id;
                snap_len_q <= (tbl_len == '0) ? LEN_ONE : tbl_len;
            end
        end
    end

    always_comb begin
        hdr_if.hdr_id = 6'h00;
        if (state_q == ISSUE)       hdr_if.hdr_id = snap_id_q;
        if (state_q == SLEEP_ISSUE) hdr_if.hdr_id = SLEEP_ID;
    end

    assign hdr_if.hdr_req = (state_q == ISSUE) || (state_q == SLEEP_ISSUE);
    assign slot_idx_o     = slot_idx_q;
    assign err_cnt_o      = err_cnt_q;
    assign busy_o         = !(state_q == IDLE || state_q == SLEEP);
    assign asleep_o       = (state_q == SLEEP);

endmodule
`default_nettype wire

// File: tb/tb_lin_schedule_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lin_schedule_ctrl : directed self-checking bench for the scheduler |
// | Revision             : 1.0                                            |
// +----------------------------------------------------------------------+
module tb_lin_schedule_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        en, tick, cfg_we, sleep_req, wake_req;
    logic [2:0]  cfg_addr;
    logic [5:0]  cfg_id;
    logic [15:0] cfg_len;
    logic [3:0]  cfg_num;
    logic [2:0]  slot_idx;
    logic [7:0]  err_cnt;
    logic        busy, asleep;
    int          checks = 0;
    int          errors = 0;

    lin_schedule_ctrl_if hif ();

    lin_schedule_ctrl #(.N_SLOTS(8), .LEN_W(16)) dut (
        .clk(clk), .reset(reset), .en_i(en), .tick_i(tick), .cfg_we_i(cfg_we),
        .cfg_addr_i(cfg_addr), .cfg_id_i(cfg_id), .cfg_len_i(cfg_len), .cfg_num_i(cfg_num),
        .sleep_req_i(sleep_req), .wake_req_i(wake_req), .hdr_if(hif),
        .slot_idx_o(slot_idx), .err_cnt_o(err_cnt), .busy_o(busy), .asleep_o(asleep)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [5:0] id, input logic [15:0] len);
        cfg_we = 1'b1; cfg_addr = a; cfg_id = id; cfg_len = len;
        step;
        cfg_we = 1'b0;
    endtask

    // Runs one slot from ISSUE: mode 0 = no response, 1 = done after 1 tick, 2 = err after 1 tick.
    task automatic run_slot(input int ack_dly, input int mode, output int ticks, output bit tmo);
        int g;
        repeat (ack_dly) step;
        hif.hdr_ack = 1'b1; step; hif.hdr_ack = 1'b0;
        ticks = 0; g = 0;
        if (mode != 0) begin
            tick = 1'b1; step; tick = 1'b0; ticks = 1;
            if (mode == 1) hif.frame_done = 1'b1; else hif.frame_err = 1'b1;
            step;
            hif.frame_done = 1'b0; hif.frame_err = 1'b0;
        end
        while (!(hif.hdr_req === 1'b1 || busy === 1'b0) && g < 64) begin
            tick = 1'b1; step; tick = 1'b0; ticks++;
            step; g++;
        end
        tmo = (g >= 64);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        step; step;
        checks++; if (hif.hdr_req !== 1'b0) begin errors++; $display("FAIL rst_hdr_req got %0b want 0", hif.hdr_req); end
        checks++; if (hif.hdr_id !== 6'h00) begin errors++; $display("FAIL rst_hdr_id got %h want 00", hif.hdr_id); end
        checks++; if (slot_idx !== 3'd0) begin errors++; $display("FAIL rst_slot got %0d want 0", slot_idx); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err got %0d want 0", err_cnt); end
        checks++; if (busy !== 1'b0 || asleep !== 1'b0) begin errors++; $display("FAIL rst_busy_asleep got %0b%0b want 00", busy, asleep); end
        reset = 1'b1;
        step;
    endtask

    task automatic test_schedule;
        int t; bit tmo;
        wr(3'd0, 6'h10, 16'd3); wr(3'd1, 6'h11, 16'd5);
        cfg_num = 4'd2; en = 1'b1;
        step;
        checks++; if (hif.hdr_req !== 1'b1 || hif.hdr_id !== 6'h10 || slot_idx !== 3'd0) begin errors++;
            $display("FAIL sched_first got req=%0b id=%h idx=%0d want 1 10 0", hif.hdr_req, hif.hdr_id, slot_idx); end
        run_slot(2, 1, t, tmo);
        checks++; if (t !== 3 || tmo) begin errors++; $display("FAIL sched_len0 got %0d ticks want 3", t); end
        checks++; if (hif.hdr_id !== 6'h11 || slot_idx !== 3'd1) begin errors++;
            $display("FAIL sched_second got id=%h idx=%0d want 11 1", hif.hdr_id, slot_idx); end
        run_slot(2, 1, t, tmo);
        checks++; if (t !== 5 || tmo) begin errors++; $display("FAIL sched_len1 got %0d ticks want 5", t); end
        checks++; if (hif.hdr_id !== 6'h10 || slot_idx !== 3'd0) begin errors++;
            $display("FAIL sched_wrap got id=%h idx=%0d want 10 0", hif.hdr_id, slot_idx); end
        en = 1'b0;
        run_slot(2, 1, t, tmo);
        checks++; if (busy !== 1'b0 || err_cnt !== 8'd0) begin errors++;
            $display("FAIL sched_stop got busy=%0b err=%0d want 0 0", busy, err_cnt); end
    endtask

    task automatic test_zero_len;
        int t; bit tmo;
        wr(3'd0, 6'h05, 16'd0);
        cfg_num = 4'd1; en = 1'b1;
        step;
        checks++; if (hif.hdr_id !== 6'h05) begin errors++; $display("FAIL zlen_id got %h want 05", hif.hdr_id); end
        en = 1'b0;
        run_slot(0, 1, t, tmo);
        checks++; if (t !== 1 || busy !== 1'b0) begin errors++; $display("FAIL zlen_len got %0d ticks busy=%0b want 1 0", t, busy); end
    endtask

    task automatic test_ack_hold;
        int t; bit tmo;
        wr(3'd0, 6'h10, 16'd3);
        cfg_num = 4'd2; en = 1'b1;
        step;
        for (int i = 0; i < 20; i++) begin
            tick = i[0];
            step;
            checks++; if (hif.hdr_req !== 1'b1 || hif.hdr_id !== 6'h10) begin errors++;
                $display("FAIL hold_req cyc %0d got req=%0b id=%h want 1 10", i, hif.hdr_req, hif.hdr_id); end
        end
        tick = 1'b0;
        run_slot(0, 1, t, tmo);
        checks++; if (t !== 3 || tmo) begin errors++; $display("FAIL hold_timer got %0d ticks want 3", t); end
        en = 1'b0;
        run_slot(0, 1, t, tmo);
        checks++; if (t !== 5 || busy !== 1'b0) begin errors++; $display("FAIL hold_end got %0d ticks busy=%0b want 5 0", t, busy); end
    endtask

    task automatic test_rewrite;
        int t; bit tmo;
        cfg_num = 4'd2; en = 1'b1;
        step;
        wr(3'd0, 6'h10, 16'd6);
        run_slot(0, 1, t, tmo);
        checks++; if (t !== 3) begin errors++; $display("FAIL rewrite_cur got %0d ticks want 3", t); end
        run_slot(0, 1, t, tmo);
        checks++; if (t !== 5) begin errors++; $display("FAIL rewrite_other got %0d ticks want 5", t); end
        en = 1'b0;
        run_slot(0, 1, t, tmo);
        checks++; if (t !== 6 || busy !== 1'b0) begin errors++; $display("FAIL rewrite_next got %0d ticks busy=%0b want 6 0", t, busy); end
    endtask

    task automatic test_errors;
        int t; bit tmo; bit tmo_any; logic [7:0] e254, e255;
        wr(3'd0, 6'h20, 16'd4);
        cfg_num = 4'd1; en = 1'b1;
        step;
        run_slot(0, 2, t, tmo);
        checks++; if (t !== 4 || err_cnt !== 8'd1) begin errors++; $display("FAIL err_frame got %0d ticks err=%0d want 4 1", t, err_cnt); end
        run_slot(0, 0, t, tmo);
        checks++; if (t !== 4 || err_cnt !== 8'd2) begin errors++; $display("FAIL err_timeout got %0d ticks err=%0d want 4 2", t, err_cnt); end
        hif.hdr_ack = 1'b1; step; hif.hdr_ack = 1'b0;
        tick = 1'b1; repeat (4) step; tick = 1'b0;
        hif.frame_done = 1'b1; step; hif.frame_done = 1'b0;
        checks++; if (err_cnt !== 8'd2 || hif.hdr_req !== 1'b1) begin errors++;
            $display("FAIL err_done_at_tmo got err=%0d req=%0b want 2 1", err_cnt, hif.hdr_req); end
        tmo_any = 1'b0; e254 = '0; e255 = '0;
        for (int i = 0; i < 260; i++) begin
            run_slot(0, 0, t, tmo);
            tmo_any |= tmo;
            if (i == 251) e254 = err_cnt;
            if (i == 252) e255 = err_cnt;
        end
        checks++; if (e254 !== 8'd254 || e255 !== 8'd255) begin errors++; $display("FAIL err_ramp got %0d,%0d want 254,255", e254, e255); end
        checks++; if (err_cnt !== 8'd255 || tmo_any) begin errors++; $display("FAIL err_sat got %0d want 255", err_cnt); end
        en = 1'b0;
        run_slot(0, 0, t, tmo);
        checks++; if (busy !== 1'b0 || err_cnt !== 8'd255) begin errors++; $display("FAIL err_stop got busy=%0b err=%0d want 0 255", busy, err_cnt); end
    endtask

    task automatic do_reset;
        reset = 1'b0; step; reset = 1'b1; step;
    endtask

    task automatic test_sleep;
        int t, g; bit tmo;
        wr(3'd0, 6'h10, 16'd3); wr(3'd1, 6'h11, 16'd5);
        cfg_num = 4'd2; en = 1'b1;
        step;
        run_slot(0, 1, t, tmo);
        checks++; if (hif.hdr_id !== 6'h11) begin errors++; $display("FAIL sleep_slot1 got %h want 11", hif.hdr_id); end
        hif.hdr_ack = 1'b1; step; hif.hdr_ack = 1'b0;
        tick = 1'b1; step; tick = 1'b0; t = 1;
        hif.frame_done = 1'b1; step; hif.frame_done = 1'b0;
        sleep_req = 1'b1; step; sleep_req = 1'b0;
        g = 0;
        while (hif.hdr_req !== 1'b1 && g < 64) begin
            tick = 1'b1; step; tick = 1'b0; t++; step; g++;
        end
        checks++; if (t !== 5 || hif.hdr_id !== 6'h3C || busy !== 1'b1) begin errors++;
            $display("FAIL sleep_issue got %0d ticks id=%h busy=%0b want 5 3c 1", t, hif.hdr_id, busy); end
        hif.hdr_ack = 1'b1; step; hif.hdr_ack = 1'b0;
        hif.frame_done = 1'b1; step; hif.frame_done = 1'b0;
        checks++; if (asleep !== 1'b1 || busy !== 1'b0 || hif.hdr_req !== 1'b0) begin errors++;
            $display("FAIL sleep_enter got asleep=%0b busy=%0b req=%0b want 1 0 0", asleep, busy, hif.hdr_req); end
        en = 1'b0;
        wake_req = 1'b1; step; wake_req = 1'b0;
        checks++; if (asleep !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'd0) begin errors++;
            $display("FAIL sleep_wake got asleep=%0b busy=%0b err=%0d want 0 0 0", asleep, busy, err_cnt); end
        en = 1'b1; step;
        checks++; if (hif.hdr_id !== 6'h10 || slot_idx !== 3'd0) begin errors++;
            $display("FAIL sleep_restart got id=%h idx=%0d want 10 0", hif.hdr_id, slot_idx); end
        run_slot(0, 1, t, tmo);
        checks++; if (hif.hdr_id !== 6'h11) begin errors++; $display("FAIL sleep_latch_clear got %h want 11", hif.hdr_id); end
        en = 1'b0;
        run_slot(0, 1, t, tmo);
    endtask

    task automatic test_idle_sleep;
        sleep_req = 1'b1; step; sleep_req = 1'b0;
        checks++; if (hif.hdr_req !== 1'b1 || hif.hdr_id !== 6'h3C || busy !== 1'b1) begin errors++;
            $display("FAIL idle_sleep got req=%0b id=%h busy=%0b want 1 3c 1", hif.hdr_req, hif.hdr_id, busy); end
        hif.hdr_ack = 1'b1; step; hif.hdr_ack = 1'b0;
        hif.frame_done = 1'b1; step; hif.frame_done = 1'b0;
        checks++; if (asleep !== 1'b1) begin errors++; $display("FAIL idle_sleep_enter got %0b want 1", asleep); end
        wake_req = 1'b1; step; wake_req = 1'b0;
        checks++; if (asleep !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL idle_sleep_wake got asleep=%0b busy=%0b want 0 0", asleep, busy); end
    endtask

    task automatic test_reset_mid;
        int t; bit tmo;
        cfg_num = 4'd2; en = 1'b1;
        step;
        run_slot(0, 2, t, tmo);
        hif.hdr_ack = 1'b1; step; hif.hdr_ack = 1'b0;
        tick = 1'b1; step; tick = 1'b0;
        checks++; if (slot_idx !== 3'd1 || err_cnt !== 8'd1 || busy !== 1'b1) begin errors++;
            $display("FAIL rmid_pre got idx=%0d err=%0d busy=%0b want 1 1 1", slot_idx, err_cnt, busy); end
        reset = 1'b0;
        step;
        checks++; if (hif.hdr_req !== 1'b0 || hif.hdr_id !== 6'h00 || slot_idx !== 3'd0 || err_cnt !== 8'd0 || busy !== 1'b0 || asleep !== 1'b0) begin errors++;
            $display("FAIL rmid_reset got req=%0b id=%h idx=%0d err=%0d busy=%0b asleep=%0b want all 0",
                     hif.hdr_req, hif.hdr_id, slot_idx, err_cnt, busy, asleep); end
        step; step;
        checks++; if (hif.hdr_req !== 1'b0) begin errors++; $display("FAIL rmid_hold got req=%0b want 0", hif.hdr_req); end
        reset = 1'b1;
        step;
        checks++; if (hif.hdr_req !== 1'b1 || hif.hdr_id !== 6'h00 || slot_idx !== 3'd0) begin errors++;
            $display("FAIL rmid_restart got req=%0b id=%h idx=%0d want 1 00 0", hif.hdr_req, hif.hdr_id, slot_idx); end
        en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; tick = 1'b0; cfg_we = 1'b0; sleep_req = 1'b0; wake_req = 1'b0;
        cfg_addr = '0; cfg_id = '0; cfg_len = '0; cfg_num = '0;
        hif.hdr_ack = 1'b0; hif.frame_done = 1'b0; hif.frame_err = 1'b0;
        test_reset;
        test_schedule;
        test_zero_len;
        test_ack_hold;
        test_rewrite;
        test_errors;
        do_reset;
        test_sleep;
        test_idle_sleep;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lin_schedule_ctrl.md
LIN_SCHEDULE_CTRL -- requirements
Module: lin_schedule_ctrl

Interface
REQ-001 Parameter N_SLOTS, default 8, number of schedule-table entries (power of two, 2..16).
REQ-002 Parameter LEN_W, default 16, width of slot length in ticks.
REQ-003 clk  input  1  clock, all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  level, run schedule when high.
REQ-006 tick  input  1  single-cycle base timebase pulse (e.g. 1 ms).
REQ-007 cfg_we  input  1  table write strobe.
REQ-008 cfg_addr  input  log2(N_SLOTS)  table entry index.
REQ-009 cfg_id  input  6  frame identifier for the entry.
REQ-010 cfg_len  input  LEN_W  slot length in ticks.
REQ-011 cfg_num  input  log2(N_SLOTS)+1  number of active entries.
REQ-012 sleep_req  input  1  pulse, request go-to-sleep frame.
REQ-013 wake_req  input  1  pulse, leave sleep.
REQ-014 hdr_req  output  1  header transmit request.
REQ-015 hdr_id  output  6  identifier for the requested header.
REQ-016 hdr_ack  input  1  header transmitter accepted the request.
REQ-017 frame_done  input  1  pulse, response finished OK.
REQ-018 frame_err  input  1  pulse, response finished with error.
REQ-019 slot_idx  output  log2(N_SLOTS)  index of current slot.
REQ-020 err_cnt  output  8  saturating count of errors plus timeouts.
REQ-021 busy  output  1  high in any state except IDLE and SLEEP.
REQ-022 asleep  output  1  high in SLEEP.

Function
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT_FRAME, SLOT_WAIT, SLEEP_ISSUE, SLEEP.
REQ-024 IDLE->ISSUE SHALL occur when en=1 and cfg_num!=0; slot_idx SHALL load 0.
REQ-025 On entry to ISSUE, the entry (id, len) at slot_idx SHALL be snapshotted; later table writes SHALL affect only subsequent loads.
REQ-026 In ISSUE and SLEEP_ISSUE, hdr_req SHALL be 1 and hdr_id stable until the cycle with hdr_ack=1; transfer occurs when hdr_req and hdr_ack are both high.
REQ-027 The slot timer SHALL clear on the accept cycle and increment on each tick thereafter.
REQ-028 snapshot len=0 SHALL be treated as 1.
REQ-029 WAIT_FRAME->SLOT_WAIT SHALL occur on frame_done or frame_err; frame_err SHALL increment err_cnt.
REQ-030 If timer reaches len in WAIT_FRAME with no done/err, err_cnt SHALL increment (timeout) and the slot SHALL end.
REQ-031 frame_done and timeout in the same cycle SHALL count as done, with no increment.
REQ-032 SLOT_WAIT SHALL end when timer reaches len.
REQ-033 At slot end slot_idx SHALL advance, wrapping to 0 after cfg_num-1, or when slot_idx >= cfg_num.
REQ-034 err_cnt SHALL saturate at 255.
REQ-035 sleep_req SHALL be latched in any busy state.
REQ-036 At the next slot end, a latched sleep_req SHALL go to SLEEP_ISSUE with hdr_id=6'h3C.
REQ-037 In SLEEP_ISSUE, accept SHALL go to WAIT_FRAME-like wait for done/err/len, then to SLEEP.
REQ-038 en=0 at a slot end SHALL go to IDLE unless sleep is latched; sleep wins.
REQ-039 SLEEP->IDLE SHALL occur on wake_req; the sleep latch SHALL clear and err_cnt is unchanged.
REQ-040 sleep_req in IDLE SHALL go directly to SLEEP_ISSUE.
REQ-041 Table writes SHALL take effect in the next cycle in any state.

Reset
REQ-042 On reset=0: state IDLE, hdr_req=0, hdr_id=0, slot_idx=0, err_cnt=0, busy=0, asleep=0, timer=0, sleep latch=0, all table entries id=0 len=0; a mid-frame reset SHALL abort without further hdr_req.

Structure
REQ-043 Package lin_sched_pkg SHALL hold the state enum, SLEEP_ID=6'h3C and ERR_MAX=255.
REQ-044 Table storage SHALL be sub-module lin_sched_table: synchronous write, combinational read.

Verification
REQ-045 cfg_num=2, {0x10,len 3},{0x11,len 5}, en=1, ack after 2 cycles, done after 1 tick -> hdr_id sequence 0x10,0x11,0x10, slot lengths 3 and 5 ticks.
REQ-046 No frame_done, len=4 -> slot ends 4 ticks after accept, err_cnt +1; 300 timeouts -> err_cnt=255.
REQ-047 sleep_req mid-slot 1 -> slot 1 completes, next hdr_id=0x3C, asleep=1 after its done; wake_req -> IDLE, busy=0.
REQ-048 hdr_ack withheld 20 cycles -> hdr_req and hdr_id held constant, timer 0.
REQ-049 Rewrite current entry's len during its slot -> current slot keeps old len, next pass uses new len.
REQ-050 reset asserted in WAIT_FRAME -> all outputs at reset values on the next edge; after release with en=1 -> restart at slot 0.
